// File: rtl/pwm_audio_out.sv
// pwm_audio_out: FIFO-buffered PCM samples driven out as 1-bit PWM, one sample per counter period
module pwm_audio_out #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [width-1:0]       count,
  input  logic [width-1:0]       sample_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  input  logic                   underrun_clr,
  output logic                   pwm_out,
  output logic                   underrun,
  output logic [$clog2(depth):0] fill_level
);
  localparam int aw = $clog2(depth);
  logic [width-1:0] mem_q [depth];
  logic [aw-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [aw:0] fill_q, fill_d;
  logic [width-1:0] duty_q, duty_d;
  logic pwm_q, pwm_d, underrun_q, underrun_d, push, pop, boundary, empty;
  assign sample_ready = fill_q != (aw+1)'(depth);
  assign pwm_out = pwm_q;
  assign underrun = underrun_q;
  assign fill_level = fill_q;
  // Next state: a boundary is count == all-ones; pop only when something is buffered
  always_comb begin
    empty = fill_q == '0;
    boundary = &count;
    push = sample_valid && sample_ready;
    pop = boundary && !empty;
    wr_d = push ? wr_q + aw'(1) : wr_q;
    rd_d = pop ? rd_q + aw'(1) : rd_q;
    fill_d = fill_q + (aw+1)'(push) - (aw+1)'(pop);
    duty_d = pop ? mem_q[rd_q] : duty_q;
    underrun_d = (boundary && empty) ? 1'b1 : underrun_clr ? 1'b0 : underrun_q;
    pwm_d = count < duty_q;
  end
  // Sample storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= sample_in;
  // Control state; duty resets to mid-scale silence
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      fill_q <= '0;
      duty_q <= {1'b1, {(width-1){1'b0}}};
      underrun_q <= 1'b0;
      pwm_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      fill_q <= fill_d;
      duty_q <= duty_d;
      underrun_q <= underrun_d;
      pwm_q <= pwm_d;
    end
endmodule

// File: tb/tb_pwm_audio_out.sv
// tb_pwm_audio_out: directed and randomized checks of pwm_audio_out against a queue-based model
module tb_pwm_audio_out;
  logic clk = 0, reset = 1, sample_valid = 0, underrun_clr = 0;
  logic [7:0] count = 0, sample_in = 0;
  logic sample_ready, pwm_out, underrun;
  logic [2:0] fill_level;
  int pass_cnt = 0, total = 0, cnt = 0;
  int q[$];
  int m_duty = 128;
  bit m_ur = 0, m_pwm = 0;

  pwm_audio_out #(.width(8), .depth(4)) dut (
    .clk(clk), .reset(reset), .count(count), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .underrun_clr(underrun_clr), .pwm_out(pwm_out), .underrun(underrun),
    .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_duty = 128;
    m_ur = 0;
    m_pwm = 0;
  endtask

  task automatic tick();
    bit psh, bnd, emp;
    emp = q.size() == 0;
    psh = sample_valid && (q.size() != 4);
    bnd = cnt == 255;
    @(posedge clk);
    #1;
    m_pwm = cnt < m_duty;
    if (bnd && !emp) m_duty = q.pop_front();
    if (psh) q.push_back(int'(sample_in));
    m_ur = (bnd && emp) ? 1'b1 : underrun_clr ? 1'b0 : m_ur;
    cnt = (cnt + 1) % 256;
    count = 8'(cnt);
  endtask

  task automatic go_to(input int c);
    while (cnt != c) tick();
  endtask

  task automatic push(input int v);
    sample_valid = 1;
    sample_in = 8'(v);
    tick();
    sample_valid = 0;
  endtask

  task automatic run_frame(output int h);
    h = 0;
    repeat (256) begin
      tick();
      h += int'(pwm_out);
    end
  endtask

  task automatic test_reset();
    int h;
    push(8'h11); push(8'h22); push(8'h33);
    go_to(100);
    #2 reset = 1;
    #1;
    model_reset();
    total++; if (fill_level !== 3'd0) $display("FAIL reset_fill got %0d want 0", fill_level); else pass_cnt++;
    total++; if (pwm_out !== 1'b0) $display("FAIL reset_pwm got %b want 0", pwm_out); else pass_cnt++;
    total++; if (underrun !== 1'b0) $display("FAIL reset_underrun got %b want 0", underrun); else pass_cnt++;
    total++; if (sample_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", sample_ready); else pass_cnt++;
    cnt = 0;
    count = 0;
    reset = 0;
    run_frame(h);
    total++; if (h !== 128) $display("FAIL reset_frame_high got %0d want 128", h); else pass_cnt++;
  endtask

  task automatic test_fill();
    int h;
    underrun_clr = 1;
    tick();
    underrun_clr = 0;
    total++; if (underrun !== 1'b0) $display("FAIL clr_nonboundary got %b want 0", underrun); else pass_cnt++;
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    total++; if (fill_level !== 3'd4) $display("FAIL fill_full got %0d want 4", fill_level); else pass_cnt++;
    total++; if (sample_ready !== 1'b0) $display("FAIL ready_full got %b want 0", sample_ready); else pass_cnt++;
    push(8'h50);
    total++; if (fill_level !== 3'd4) $display("FAIL drop_fifth got %0d want 4", fill_level); else pass_cnt++;
    go_to(255);
    total++; if (sample_ready !== 1'b0) $display("FAIL ready_at_boundary got %b want 0", sample_ready); else pass_cnt++;
    tick();
    total++; if (sample_ready !== 1'b1) $display("FAIL ready_after_pop got %b want 1", sample_ready); else pass_cnt++;
    total++; if (fill_level !== 3'd3) $display("FAIL fill_after_pop got %0d want 3", fill_level); else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      run_frame(h);
      total++; if (h !== 16 * i) $display("FAIL frame_%0d_high got %0d want %0d", i, h, 16 * i); else pass_cnt++;
    end
    total++; if (underrun !== 1'b1) $display("FAIL underrun_empty got %b want 1", underrun); else pass_cnt++;
    total++; if (fill_level !== 3'd0) $display("FAIL fill_drained got %0d want 0", fill_level); else pass_cnt++;
  endtask

  task automatic test_underrun();
    int h;
    tick();
    underrun_clr = 1;
    tick();
    underrun_clr = 0;
    total++; if (underrun !== 1'b0) $display("FAIL underrun_clr got %b want 0", underrun); else pass_cnt++;
    go_to(255);
    underrun_clr = 1;
    tick();
    underrun_clr = 0;
    total++; if (underrun !== 1'b1) $display("FAIL set_beats_clr got %b want 1", underrun); else pass_cnt++;
    run_frame(h);
    total++; if (h !== 64) $display("FAIL duty_hold got %0d want 64", h); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    int h;
    go_to(255);
    push(8'h80);
    total++; if (underrun !== 1'b1) $display("FAIL push_empty_boundary_ur got %b want 1", underrun); else pass_cnt++;
    total++; if (fill_level !== 3'd1) $display("FAIL push_empty_boundary_fill got %0d want 1", fill_level); else pass_cnt++;
    run_frame(h);
    total++; if (h !== 64) $display("FAIL no_bypass got %0d want 64", h); else pass_cnt++;
    total++; if (fill_level !== 3'd0) $display("FAIL late_load_fill got %0d want 0", fill_level); else pass_cnt++;
    run_frame(h);
    total++; if (h !== 128) $display("FAIL late_load_frame got %0d want 128", h); else pass_cnt++;
    push(8'h30); push(8'h00);
    go_to(255);
    push(8'hFF);
    total++; if (fill_level !== 3'd2) $display("FAIL push_pop_fill got %0d want 2", fill_level); else pass_cnt++;
  endtask

  task automatic test_extremes();
    int h;
    run_frame(h);
    total++; if (h !== 48) $display("FAIL frame_30 got %0d want 48", h); else pass_cnt++;
    run_frame(h);
    total++; if (h !== 0) $display("FAIL frame_00 got %0d want 0", h); else pass_cnt++;
    run_frame(h);
    total++; if (h !== 255) $display("FAIL frame_ff got %0d want 255", h); else pass_cnt++;
    push(8'h20);
    go_to(100);
    cnt = 0;
    count = 0;
    repeat (10) tick();
    total++; if (fill_level !== 3'd1) $display("FAIL jump_no_pop got %0d want 1", fill_level); else pass_cnt++;
    total++; if (pwm_out !== 1'b1) $display("FAIL jump_duty_kept got %b want 1", pwm_out); else pass_cnt++;
    go_to(255);
    tick();
    run_frame(h);
    total++; if (h !== 32) $display("FAIL after_jump_frame got %0d want 32", h); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      sample_valid = ($urandom_range(0, 2) != 0);
      sample_in = 8'($urandom);
      underrun_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin
        cnt = int'($urandom_range(0, 255));
        count = 8'(cnt);
      end
      tick();
      total++; if (pwm_out !== m_pwm) $display("FAIL rnd_pwm cyc %0d got %b want %b", i, pwm_out, m_pwm); else pass_cnt++;
      total++; if (int'(fill_level) !== q.size()) $display("FAIL rnd_fill cyc %0d got %0d want %0d", i, fill_level, q.size()); else pass_cnt++;
      total++; if (underrun !== m_ur) $display("FAIL rnd_underrun cyc %0d got %b want %b", i, underrun, m_ur); else pass_cnt++;
      total++; if (sample_ready !== (q.size() != 4)) $display("FAIL rnd_ready cyc %0d got %b want %b", i, sample_ready, q.size() != 4); else pass_cnt++;
    end
    sample_valid = 0;
    underrun_clr = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    test_reset();
    test_fill();
    test_underrun();
    test_same_cycle();
    test_extremes();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/pwm_audio_out.md
Name: pwm_audio_out

Overview:
- Downstream consumer of the free-running frame counter; converts a stream of PCM samples into a 1-bit PWM audio output.
- Buffers incoming samples in a small FIFO using a valid/ready handshake.
- Loads one sample per counter period, at the wrap boundary, and drives the PWM pin by comparing the counter value against the active sample.

Parameters:
- width, 8, bit width of the counter input, the samples and the PWM resolution; PWM period = 2^width clocks.
- depth, 4, FIFO depth in samples; power of two, >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- count  input  width  current value of the upstream free-running counter; increments by 1 per clk and wraps all-ones -> 0.
- sample_in  input  width  unsigned PCM sample (duty value).
- sample_valid  input  1  sample_in is valid this cycle.
- sample_ready  output  1  FIFO can accept a sample this cycle.
- underrun_clr  input  1  clears the sticky underrun flag.
- pwm_out  output  1  registered PWM audio output.
- underrun  output  1  sticky flag: a frame boundary found the FIFO empty.
- fill_level  output  clog2(depth)+1  number of samples currently in the FIFO.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - FIFO empty; fill_level = 0.
  - Active duty register = 2^(width-1), the mid-scale "silence" value.
  - pwm_out = 0; underrun = 0.
  - Read and write pointers = 0.
- sample_ready:
  - sample_ready = (fill_level != depth), driven combinationally from registered state.
  - It is therefore 1 during and immediately after reset.
- Push: on a clk edge with sample_valid && sample_ready, sample_in is written at the write pointer, which advances modulo depth.
  - sample_valid while not ready: the sample is ignored, not stored.
- Frame boundary: a cycle in which count == all-ones. The next counter value is 0, which starts a new PWM period.
- On the clk edge of a frame boundary:
  - FIFO non-empty: the active duty register loads the FIFO head and the read pointer advances (pop).
  - FIFO empty: the active duty register holds its previous value and underrun is set to 1.
- Simultaneous push and pop: fill_level is unchanged and both pointers advance.
- Push into an empty FIFO on a frame-boundary cycle:
  - No pop occurs, underrun is set, and the pushed sample waits for the next boundary.
  - Push is not bypassed into the active duty register.
- Full FIFO on a frame boundary: the pop frees one slot. sample_ready is still 0 in that cycle because it reflects pre-edge state; it rises the following cycle.
- PWM output:
  - Each edge, pwm_out <= (count < duty_active), with unsigned compare on width bits.
  - Latency is one clk from count to pwm_out.
  - The compare uses duty_active as it stands before the edge. On the boundary cycle itself the old value is used; the new duty takes effect from count = 0.
  - Duty 0: pwm_out is constantly 0.
  - Duty all-ones: pwm_out is high for 2^width - 1 clocks per period and low for 1.
- underrun flag:
  - Sticky until a clk edge with underrun_clr = 1.
  - If a set condition and underrun_clr occur on the same edge, set wins and underrun stays 1.
- count discontinuity: count jumping to 0 (upstream reset) is not a boundary. No pop occurs, and PWM continues with the current duty.
- Reset mid-operation: all state returns to the reset values immediately, without waiting for clk, and buffered samples are discarded.
- fill_level always equals pushes minus pops since reset and never exceeds depth.

Test Plan (width=8, depth=4):
- Reset: assert reset mid-frame with 3 samples buffered -> fill_level=0, pwm_out=0, underrun=0, sample_ready=1 with no clk edge; after release, pwm_out is high for count 0..127 and low for 128..255 (duty 128).
- Fill and backpressure: push 0x10, 0x20, 0x30, 0x40 back-to-back -> fill_level=4, sample_ready=0; a 5th valid push of 0x50 is dropped.
- Frame load:
  - First boundary (count=255) pops 0x10, so next frame pwm_out is high for exactly 16 clocks.
  - Consecutive frames then give 32, 48 and 64 high clocks.
  - sample_ready returns to 1 one cycle after the first pop.
- Underrun: leave the FIFO empty across a boundary -> underrun=1 and the duty holds at its last value. Pulse underrun_clr on a non-boundary cycle -> underrun=0. Assert underrun_clr on an empty-FIFO boundary -> underrun stays 1.
- Same-cycle events:
  - Push 0x80 into an empty FIFO at count=255 -> underrun set and fill_level=1; the sample loads at the next boundary.
  - Push at a boundary with fill_level=2 -> fill_level stays 2.
- Extremes: sample 0x00 -> pwm_out 0 for the whole frame; sample 0xFF -> 255 high clocks and 1 low. Force count 100 -> 0 mid-frame -> no pop and fill_level unchanged.
